// File: rtl/data_memory_responder_pkg.sv
// Memory map, status layout and address-decode helpers shared by the responder,
// its console FIFO and anything that needs to talk to the I/O page.
package data_memory_responder_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_0000;

  localparam logic [3:0] OFF_TIMER   = 4'h0;
  localparam logic [3:0] OFF_GPIO    = 4'h4;
  localparam logic [3:0] OFF_CONSOLE = 4'h8;
  localparam logic [3:0] OFF_STATUS  = 4'hC;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_FAULT = 3;

  typedef enum logic [2:0] {
    SEL_BAD,
    SEL_RAM,
    SEL_TIMER,
    SEL_GPIO,
    SEL_CONSOLE,
    SEL_STATUS
  } sel_e;

  // Field order matches the STATUS register bit positions, MSB first.
  typedef struct packed {
    logic fault;
    logic ovf;
    logic full;
    logic empty;
  } status_t;

  function automatic sel_e io_sel(input logic [3:0] off);
    sel_e s;
    case (off)
      OFF_TIMER:   s = SEL_TIMER;
      OFF_GPIO:    s = SEL_GPIO;
      OFF_CONSOLE: s = SEL_CONSOLE;
      OFF_STATUS:  s = SEL_STATUS;
      default:     s = SEL_BAD;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] status_word(input status_t st);
    return {28'b0, st};
  endfunction

endpackage

// File: rtl/data_memory_responder_sync_fifo.sv
// Pointer-plus-count synchronous FIFO. A push while full is accepted only when a
// pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop) & rst;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_memory_responder.sv
// CPU data-memory responder: word RAM plus a 16-byte I/O page holding a cycle
// timer, GPIO, a console TX FIFO and a status register. Reads are combinational.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  output logic [31:0] mem_read_data,
  output logic [31:0] gpio_out,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        addr_fault
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  sel_e              sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              bad, wr_ok, fault_event;
  logic              ram_we, timer_clr, gpio_we, con_push, status_we;
  logic              con_pop, fifo_full, fifo_empty;
  logic [31:0]       rd_word;
  status_t           status;

  logic [31:0] timer_q, timer_d;
  logic [31:0] gpio_q, gpio_d;
  logic        ovf_q, ovf_d;
  logic        fault_q, fault_d;
  logic        addr_fault_q, addr_fault_d;

  logic [31:0] ram_q [RAM_WORDS];

  // Address decode: alignment first, then RAM window, then the I/O page.
  always_comb begin
    sel     = SEL_BAD;
    ram_idx = data_addr[RAM_AW+1:2];
    if (data_addr[1:0] != 2'b00) begin
      sel = SEL_BAD;
    end else if (data_addr[31:RAM_AW+2] == '0) begin
      sel = SEL_RAM;
    end else if (data_addr[31:4] == IO_BASE[31:4]) begin
      sel = io_sel(data_addr[3:0]);
    end
  end

  assign status = '{fault: fault_q, ovf: ovf_q, full: fifo_full, empty: fifo_empty};

  always_comb begin
    rd_word = 32'h0;
    case (sel)
      SEL_RAM:    rd_word = ram_q[ram_idx];
      SEL_TIMER:  rd_word = timer_q;
      SEL_GPIO:   rd_word = gpio_q;
      SEL_STATUS: rd_word = status_word(status);
      default:    rd_word = 32'h0;
    endcase
    mem_read_data = mem_read_en ? rd_word : 32'h0;
  end

  // Write strobes. A simultaneous read+write is flagged but the write still lands.
  always_comb begin
    bad         = (mem_read_en | mem_write_en) & (sel == SEL_BAD);
    fault_event = bad | (mem_read_en & mem_write_en);
    wr_ok       = mem_write_en & ~bad;
    ram_we      = wr_ok & (sel == SEL_RAM) & rst;
    timer_clr   = wr_ok & (sel == SEL_TIMER);
    gpio_we     = wr_ok & (sel == SEL_GPIO);
    con_push    = wr_ok & (sel == SEL_CONSOLE);
    status_we   = wr_ok & (sel == SEL_STATUS);
    con_pop     = ~fifo_empty & con_ready;
  end

  // Next-state for timer, GPIO and the sticky flags; a new event beats a clear.
  always_comb begin
    timer_d      = timer_clr ? 32'h0 : timer_q + 32'h1;
    gpio_d       = gpio_we ? mem_write_data : gpio_q;
    ovf_d        = ovf_q;
    fault_d      = fault_q;
    addr_fault_d = fault_event;
    if (status_we && mem_write_data[ST_OVF])   ovf_d   = 1'b0;
    if (status_we && mem_write_data[ST_FAULT]) fault_d = 1'b0;
    if (con_push && fifo_full && !con_pop)     ovf_d   = 1'b1;
    if (fault_event)                           fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_q      <= 32'h0;
      gpio_q       <= 32'h0;
      ovf_q        <= 1'b0;
      fault_q      <= 1'b0;
      addr_fault_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      gpio_q       <= gpio_d;
      ovf_q        <= ovf_d;
      fault_q      <= fault_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= mem_write_data;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (con_push),
    .push_data (mem_write_data[7:0]),
    .pop       (con_pop),
    .pop_data  (con_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign con_valid  = ~fifo_empty;
  assign gpio_out   = gpio_q;
  assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: directed loads/stores push expected
// read data and console bytes into queues that negedge monitors pop and compare.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam logic [31:0] A_TIMER   = IO_BASE_DEF + 32'(OFF_TIMER);
  localparam logic [31:0] A_GPIO    = IO_BASE_DEF + 32'(OFF_GPIO);
  localparam logic [31:0] A_CONSOLE = IO_BASE_DEF + 32'(OFF_CONSOLE);
  localparam logic [31:0] A_STATUS  = IO_BASE_DEF + 32'(OFF_STATUS);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] mem_write_data;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_read_data;
  logic [31:0] gpio_out;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        addr_fault;

  logic [31:0] exp_q[$];
  logic [7:0]  con_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  data_memory_responder dut (
    .clk            (clk),
    .rst            (rst),
    .data_addr      (data_addr),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .gpio_out       (gpio_out),
    .con_data       (con_data),
    .con_valid      (con_valid),
    .con_ready      (con_ready),
    .addr_fault     (addr_fault)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitors: sample away from the active edge
  always @(negedge clk) begin
    if (rst && mem_read_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got %h required no read", mem_read_data);
      end else begin
        check("rd_data", mem_read_data, exp_q.pop_front());
      end
    end
    if (con_valid && con_ready) begin
      if (con_q.size() == 0) begin
        n_checks++;
        $display("FAIL con_unexpected: got %h required no byte", con_data);
      end else begin
        check("con_data", 32'(con_data), 32'(con_q.pop_front()));
      end
    end
  end

  // Driver tasks: inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    data_addr      = a;
    mem_write_data = d;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b1;
    tick();
    mem_write_en   = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] e);
    data_addr    = a;
    mem_read_en  = 1'b1;
    mem_write_en = 1'b0;
    exp_q.push_back(e);
    tick();
    mem_read_en  = 1'b0;
  endtask

  task automatic rd_wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    data_addr      = a;
    mem_write_data = d;
    mem_read_en    = 1'b1;
    mem_write_en   = 1'b1;
    exp_q.push_back(e);
    tick();
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
  endtask

  task automatic con_push(input logic [7:0] b, input bit expect_out);
    if (expect_out) con_q.push_back(b);
    store(A_CONSOLE, {24'h0, b});
  endtask

  initial begin
    rst = 1'b0;
    data_addr = 32'h0;
    mem_write_data = 32'h0;
    mem_read_en = 1'b0;
    mem_write_en = 1'b0;
    con_ready = 1'b0;
    repeat (3) tick();
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_con_valid", 32'(con_valid), 32'h0);
    check("rst_addr_fault", 32'(addr_fault), 32'h0);
    rst = 1'b1;

    // Timer: 5 idle cycles after reset release, clear by write, wrap
    idle(5);
    load(A_TIMER, 32'd5);
    store(A_TIMER, 32'h1234_5678);
    load(A_TIMER, 32'd0);
    force dut.timer_q = 32'hFFFF_FFFF;
    data_addr = A_TIMER;
    mem_read_en = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    #1 release dut.timer_q;
    tick();
    load(A_TIMER, 32'd0);

    // RAM store/load, read disabled
    store(32'h10, 32'hDEAD_BEEF);
    load(32'h10, 32'hDEAD_BEEF);
    store(32'hFFC, 32'h0BAD_F00D);
    load(32'hFFC, 32'h0BAD_F00D);
    data_addr = 32'h10;
    #1 check("rd_disabled", mem_read_data, 32'h0);
    load(A_STATUS, 32'h1);

    // Console overflow then ordered drain
    for (int i = 0; i < 9; i++) con_push(8'h41 + 8'(i), i < 8);
    load(A_STATUS, 32'h6);
    check("con_head", 32'(con_data), 32'h41);
    con_ready = 1'b1;
    idle(8);
    con_ready = 1'b0;
    check("con_drained", 32'(con_q.size()), 32'h0);
    load(A_STATUS, 32'h5);
    load(A_CONSOLE, 32'h0);

    // Bad accesses and sticky clears
    load(32'h0000_0002, 32'h0);
    check("af_pulse_a", 32'(addr_fault), 32'h1);
    idle(1);
    check("af_low_a", 32'(addr_fault), 32'h0);
    load(32'h8000_0000, 32'h0);
    check("af_pulse_b", 32'(addr_fault), 32'h1);
    idle(1);
    check("af_low_b", 32'(addr_fault), 32'h0);
    load(A_STATUS, 32'hD);
    store(A_STATUS, 32'h8);
    load(A_STATUS, 32'h5);
    store(A_STATUS, 32'h4);
    load(A_STATUS, 32'h1);
    store(32'h12, 32'hFFFF_FFFF);
    check("af_bad_write", 32'(addr_fault), 32'h1);
    load(32'h10, 32'hDEAD_BEEF);
    load(A_STATUS, 32'h9);
    store(A_STATUS, 32'h8);
    store(A_GPIO, 32'hA5A5_0001);
    rd_wr(A_GPIO, 32'h0000_BEEF, 32'hA5A5_0001);
    check("rdwr_gpio", gpio_out, 32'h0000_BEEF);
    check("af_rdwr", 32'(addr_fault), 32'h1);
    load(A_STATUS, 32'h9);
    store(A_STATUS, 32'hC);
    load(A_STATUS, 32'h1);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) con_push(8'h61 + 8'(i), 1'b1);
    con_ready = 1'b1;
    con_push(8'h5A, 1'b1);
    con_ready = 1'b0;
    load(A_STATUS, 32'h2);
    con_ready = 1'b1;
    idle(8);
    con_ready = 1'b0;
    check("con_drained2", 32'(con_q.size()), 32'h0);
    load(A_STATUS, 32'h1);

    // Reset beats a concurrent GPIO store; RAM survives
    store(A_GPIO, 32'h0000_1234);
    check("gpio_set", gpio_out, 32'h0000_1234);
    con_push(8'h77, 1'b0);
    check("con_valid_set", 32'(con_valid), 32'h1);
    rst = 1'b0;
    store(A_GPIO, 32'h0000_5678);
    rst = 1'b1;
    check("rst2_gpio", gpio_out, 32'h0);
    check("rst2_con_valid", 32'(con_valid), 32'h0);
    check("rst2_addr_fault", 32'(addr_fault), 32'h0);
    load(A_TIMER, 32'd0);
    load(32'h10, 32'hDEAD_BEEF);
    load(A_STATUS, 32'h1);

    idle(2);
    check("rd_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
